// File: rtl/or1200_vlx_pkg.sv
// Shared types and constants for the VLX bit reader.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package or1200_vlx_pkg;

    // Byte-fetch sequencer states
    typedef enum logic {
        IDLE  = 1'b0,
        FETCH = 1'b1
    } vlx_state_e;

    // SPR addresses; address 3 aliases VLX_SPR_ADDR
    localparam logic [1:0] VLX_SPR_STAT = 2'd0;
    localparam logic [1:0] VLX_SPR_BUF  = 2'd1;
    localparam logic [1:0] VLX_SPR_ADDR = 2'd2;

    // JPEG marker prefix; a 0x00 following it is a stuffing byte
    localparam logic [7:0] JPEG_FF = 8'hFF;

    // Refill while the buffered bit count is at or below this level
    localparam int FILL_THR = 24;

endpackage

// File: rtl/or1200_vlx_rd_if.sv
// Bundles the memory, CPU get-bits and SPR signals of the VLX bit reader.
// Latency: n/a (wiring only).
// Backpressure: n/a; stall_cpu_o and ack_i carry the flow control.
// Ports:
//   memory : ack_i, dat_i in; vlx_addr_o, load_byte_o out
//   cpu    : get_bits_op_i, num_bits_to_read_i in; bits_o, stall_cpu_o out
//   spr    : spr_cs, spr_write, spr_addr, spr_dat_i in; spr_dat_o out
// master = environment (CPU + memory), slave = the reader.
interface or1200_vlx_rd_if;
    logic        ack_i;
    logic [31:0] dat_i;
    logic        get_bits_op_i;
    logic [4:0]  num_bits_to_read_i;
    logic        spr_cs;
    logic        spr_write;
    logic [1:0]  spr_addr;
    logic [31:0] spr_dat_i;
    logic [31:0] spr_dat_o;
    logic        stall_cpu_o;
    logic [31:0] vlx_addr_o;
    logic        load_byte_o;
    logic [31:0] bits_o;

    modport master (
        output ack_i, dat_i, get_bits_op_i, num_bits_to_read_i,
               spr_cs, spr_write, spr_addr, spr_dat_i,
        input  spr_dat_o, stall_cpu_o, vlx_addr_o, load_byte_o, bits_o
    );

    modport slave (
        input  ack_i, dat_i, get_bits_op_i, num_bits_to_read_i,
               spr_cs, spr_write, spr_addr, spr_dat_i,
        output spr_dat_o, stall_cpu_o, vlx_addr_o, load_byte_o, bits_o
    );
endinterface

// File: rtl/or1200_vlx_rd_fetch.sv
// Byte fetcher: address counter, load FSM, lane select and 0xFF00 unstuffing.
// Latency: one IDLE cycle between loads; byte strobe is combinational with ack_i.
// Backpressure: load_byte_o holds until ack_i; refill pauses while cnt_i > FILL_THR.
// Ports: clk_i/rst_i; cnt_i = buffered bit count; init_wr_i/init_addr_i = address
// restart; ack_i/dat_i = memory return; outputs load request, address,
// flush_pend_o and the accepted byte (byte_vld_o/byte_dat_o).
module or1200_vlx_rd_fetch #(
    parameter int FILL_THR = 24
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [5:0]  cnt_i,
    input  logic        init_wr_i,
    input  logic [31:0] init_addr_i,
    input  logic        ack_i,
    input  logic [31:0] dat_i,
    output logic        load_byte_o,
    output logic [31:0] vlx_addr_o,
    output logic        flush_pend_o,
    output logic        byte_vld_o,
    output logic [7:0]  byte_dat_o
);
    import or1200_vlx_pkg::vlx_state_e;
    import or1200_vlx_pkg::IDLE;
    import or1200_vlx_pkg::FETCH;
    import or1200_vlx_pkg::JPEG_FF;

    vlx_state_e  state_q, state_d;
    logic [31:0] vlx_addr_q;
    logic        prev_ff_q;
    logic        flush_pend_q;
    logic [7:0]  lane_byte;
    logic        acked;
    logic        stuffed;

    // Big-endian lanes: address offset 0 is the most significant byte
    always_comb begin
        case (vlx_addr_q[1:0])
            2'd0:    lane_byte = dat_i[31:24];
            2'd1:    lane_byte = dat_i[23:16];
            2'd2:    lane_byte = dat_i[15:8];
            default: lane_byte = dat_i[7:0];
        endcase
    end

    assign acked   = (state_q == FETCH) && ack_i;
    assign stuffed = prev_ff_q && (lane_byte == 8'h00);

    // A load issued before an address restart still completes, but its
    // data belongs to the old stream and is dropped.
    assign byte_vld_o   = acked && !init_wr_i && !flush_pend_q && !stuffed;
    assign byte_dat_o   = lane_byte;
    assign vlx_addr_o   = vlx_addr_q;
    assign flush_pend_o = flush_pend_q;

    always_comb begin
        state_d     = state_q;
        load_byte_o = 1'b0;
        case (state_q)
            IDLE: begin
                if ((cnt_i <= 6'(FILL_THR)) && !init_wr_i) begin
                    state_d = FETCH;
                end
            end
            FETCH: begin
                load_byte_o = 1'b1;
                if (ack_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            vlx_addr_q   <= '0;
            prev_ff_q    <= 1'b0;
            flush_pend_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (init_wr_i) begin
                vlx_addr_q   <= init_addr_i;
                prev_ff_q    <= 1'b0;
                // Only a load still waiting for its ack needs flushing
                flush_pend_q <= (state_q == FETCH) && !ack_i;
            end else if (acked) begin
                flush_pend_q <= 1'b0;
                if (!flush_pend_q) begin
                    vlx_addr_q <= vlx_addr_q + 32'd1;
                    // A discarded stuffing byte is 0x00, so this also clears it
                    prev_ff_q  <= (lane_byte == JPEG_FF);
                end
            end
        end
    end

endmodule

// File: rtl/or1200_vlx_rd.sv
// VLX bit reader: MSB-first 32-bit bit buffer fed by byte loads, drained by get-bits.
// Latency: get-bits result is combinational in the request cycle when enough bits are held.
// Backpressure: stall_cpu_o holds the CPU while the request exceeds the buffered count.
// Ports: clk_i, rst_i (sync, active-high); bus = or1200_vlx_rd_if.slave carrying
// memory load, CPU get-bits and SPR access signals.
module or1200_vlx_rd #(
    parameter int BUF_W    = 32,
    parameter int FILL_THR = 24
) (
    input  logic           clk_i,
    input  logic           rst_i,
    or1200_vlx_rd_if.slave bus
);
    import or1200_vlx_pkg::VLX_SPR_STAT;
    import or1200_vlx_pkg::VLX_SPR_BUF;

    logic [BUF_W-1:0] bit_buf_q, bit_buf_d, buf_shift;
    logic [5:0]       cnt_q, cnt_d, cnt_shift;
    logic [5:0]       n_ext, n_take;
    logic             init_wr;
    logic             stall;
    logic             take;
    logic             byte_vld;
    logic [7:0]       byte_dat;
    logic             flush_pend;
    logic             load_byte;
    logic [31:0]      vlx_addr;

    assign init_wr = bus.spr_cs && bus.spr_write && bus.spr_addr[1];
    assign n_ext   = {1'b0, bus.num_bits_to_read_i};

    // During a flush the buffer is about to be refilled from the new address
    assign stall  = bus.get_bits_op_i && (flush_pend || (n_ext > cnt_q));
    assign take   = bus.get_bits_op_i && !stall && (n_ext != 6'd0);
    assign n_take = take ? n_ext : 6'd0;

    or1200_vlx_rd_fetch #(
        .FILL_THR (FILL_THR)
    ) u_fetch (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .cnt_i        (cnt_q),
        .init_wr_i    (init_wr),
        .init_addr_i  (bus.spr_dat_i),
        .ack_i        (bus.ack_i),
        .dat_i        (bus.dat_i),
        .load_byte_o  (load_byte),
        .vlx_addr_o   (vlx_addr),
        .flush_pend_o (flush_pend),
        .byte_vld_o   (byte_vld),
        .byte_dat_o   (byte_dat)
    );

    // Consume first, then append the new byte right after the surviving bits
    always_comb begin
        buf_shift = bit_buf_q << n_take;
        cnt_shift = cnt_q - n_take;
        bit_buf_d = buf_shift;
        cnt_d     = cnt_shift;
        if (byte_vld) begin
            bit_buf_d = buf_shift | ({byte_dat, {(BUF_W-8){1'b0}}} >> cnt_shift);
            cnt_d     = cnt_shift + 6'd8;
        end
        if (init_wr) begin
            bit_buf_d = '0;
            cnt_d     = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            bit_buf_q <= '0;
            cnt_q     <= '0;
        end else begin
            bit_buf_q <= bit_buf_d;
            cnt_q     <= cnt_d;
        end
    end

    // Unused buffer bits are always zero, so a plain right shift right-aligns
    assign bus.bits_o = (bus.get_bits_op_i && (n_ext != 6'd0))
                      ? (bit_buf_q >> (6'(BUF_W) - n_ext)) : '0;

    always_comb begin
        bus.spr_dat_o = '0;
        if (bus.spr_cs && !bus.spr_write) begin
            case (bus.spr_addr)
                VLX_SPR_STAT: bus.spr_dat_o = {26'b0, cnt_q};
                VLX_SPR_BUF:  bus.spr_dat_o = bit_buf_q;
                default:      bus.spr_dat_o = vlx_addr;
            endcase
        end
    end

    assign bus.stall_cpu_o = stall;
    assign bus.load_byte_o = load_byte;
    assign bus.vlx_addr_o  = vlx_addr;

endmodule

// File: tb/tb_or1200_vlx_rd.sv
// Self-checking bench for or1200_vlx_rd: bit-queue reference model plus directed cases.
// Latency: n/a.
// Backpressure: CPU requests are held while stalled; memory acks after a programmable wait.
module tb_or1200_vlx_rd;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    or1200_vlx_rd_if vif ();

    or1200_vlx_rd #(.BUF_W(32), .FILL_THR(24)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (vif)
    );

    logic [7:0]  mem [0:1023];
    int          n_cmp = 0;
    int          n_bad = 0;

    // stimulus
    logic        op;
    logic [4:0]  nb;
    logic        cs, we;
    logic [1:0]  sa;
    logic [31:0] sd;
    int          lat = 0;
    int          wcnt = 0;
    bit          rand_lat = 0;

    // reference model: the unstuffed bit stream still held, oldest first
    bit          mq[$];
    logic [31:0] maddr = 0;
    bit          mff = 0;
    bit          mflush = 0;

    // samples of the DUT outputs in the current cycle
    logic        s_stall, s_load;
    logic [31:0] s_bits, s_spr, s_addr;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            if (n_bad <= 30) $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] model_bits(input int n);
        logic [31:0] r = 0;
        for (int i = 0; i < n; i++) r = {r[30:0], mq[i]};
        return r;
    endfunction

    function automatic logic [31:0] model_buf();
        logic [31:0] r = 0;
        for (int i = 0; i < 32; i++) r[31-i] = (i < mq.size()) ? mq[i] : 1'b0;
        return r;
    endfunction

    function automatic logic [31:0] word_at(input logic [31:0] a);
        logic [9:0] b;
        b = {a[9:2], 2'b00};
        return {mem[b], mem[b | 10'd1], mem[b | 10'd2], mem[b | 10'd3]};
    endfunction

    // One clock: memory responds, outputs are compared, the model advances.
    task automatic step();
        bit          ack, winit, exp_stall;
        int          cnt;
        logic [7:0]  b;
        logic [31:0] exp_spr;
        vif.get_bits_op_i      = op;
        vif.num_bits_to_read_i = nb;
        vif.spr_cs    = cs;
        vif.spr_write = we;
        vif.spr_addr  = sa;
        vif.spr_dat_i = sd;
        ack = 0;
        if (!rst && vif.load_byte_o) begin
            if (wcnt >= lat) begin
                ack  = 1;
                wcnt = 0;
                if (rand_lat) lat = $urandom_range(0, 3);
            end else begin
                wcnt++;
            end
        end else begin
            wcnt = 0;
        end
        vif.ack_i = ack;
        vif.dat_i = word_at(vif.vlx_addr_o);
        #1;
        s_stall = vif.stall_cpu_o;
        s_load  = vif.load_byte_o;
        s_bits  = vif.bits_o;
        s_spr   = vif.spr_dat_o;
        s_addr  = vif.vlx_addr_o;
        cnt       = mq.size();
        winit     = cs && we && sa[1];
        exp_stall = op && (mflush || (int'(nb) > cnt));
        if (!rst) begin
            check("stall", 32'(s_stall), 32'(exp_stall));
            if (op && !exp_stall) check("bits", s_bits, model_bits(int'(nb)));
            if (cs && !we) begin
                exp_spr = (sa == 2'd0) ? 32'(cnt) : (sa == 2'd1) ? model_buf() : maddr;
                check("spr_read", s_spr, exp_spr);
            end
            if (s_load) begin
                check("load_addr", s_addr, maddr);
                check("load_only_when_low", 32'(cnt <= 24), 32'd1);
            end
        end
        if (rst) begin
            mq.delete();
            maddr = 0; mff = 0; mflush = 0;
        end else begin
            if (op && !exp_stall && nb != 0) repeat (int'(nb)) void'(mq.pop_front());
            if (winit) begin
                mq.delete();
                mff    = 0;
                maddr  = sd;
                mflush = s_load && !ack;
            end else if (ack) begin
                if (mflush) begin
                    mflush = 0;
                end else begin
                    b = mem[maddr[9:0]];
                    if (mff && b == 8'h00) begin
                        mff = 0;
                    end else begin
                        for (int i = 7; i >= 0; i--) mq.push_back(b[i]);
                        mff = (b == 8'hFF);
                    end
                    maddr = maddr + 32'd1;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic wait_full();
        int k = 0;
        while (!(mq.size() == 32 && !vif.load_byte_o) && k < 80) begin
            step();
            k++;
        end
        check("fill_timeout", 32'(mq.size() == 32), 32'd1);
    endtask

    task automatic spr_init(input logic [31:0] a);
        cs = 1; we = 1; sa = 2'd2; sd = a;
        step();
        cs = 0; we = 0;
    endtask

    task automatic spr_read(input logic [1:0] a);
        cs = 1; we = 0; sa = a;
        step();
        cs = 0;
    endtask

    task automatic get(input logic [4:0] n);
        op = 1; nb = n;
        step();
        op = 0;
    endtask

    initial begin
        int r;
        int k;
        bit found;
        rst = 1; op = 0; nb = 0; cs = 0; we = 0; sa = 0; sd = 0;
        for (int i = 0; i < 1024; i++) begin
            r = $urandom_range(0, 9);
            mem[i] = (r < 2) ? 8'hFF : (r < 4) ? 8'h00 : 8'($urandom);
        end
        mem[10'h100] = 8'hA5; mem[10'h101] = 8'h3C; mem[10'h102] = 8'h0F; mem[10'h103] = 8'hF0;
        mem[10'h140] = 8'hFF; mem[10'h141] = 8'h00; mem[10'h142] = 8'h12; mem[10'h143] = 8'h33;
        mem[10'h144] = 8'h44;
        mem[10'h180] = 8'hFF; mem[10'h181] = 8'hFF; mem[10'h182] = 8'h00; mem[10'h183] = 8'h11;
        mem[10'h184] = 8'h22;
        mem[10'h1C0] = 8'hBE; mem[10'h1C1] = 8'hEF;
        mem[10'h1E0] = 8'h55; mem[10'h1E1] = 8'h66; mem[10'h1E2] = 8'h77;
        mem[10'h200] = 8'h01; mem[10'h201] = 8'h02; mem[10'h202] = 8'h03; mem[10'h203] = 8'h04;
        mem[10'h220] = 8'hEE;

        step(); step();
        rst = 0;

        // reset state
        spr_read(2'd0);
        check("rst_load", 32'(s_load), 32'd0);
        check("rst_addr", s_addr, 32'd0);
        check("rst_stall", 32'(s_stall), 32'd0);
        check("rst_bits", s_bits, 32'd0);
        check("rst_cnt", s_spr, 32'd0);

        // plain fill and three reads
        lat = 0;
        spr_init(32'h100);
        wait_full();
        spr_read(2'd0);
        check("fill_cnt", s_spr, 32'd32);
        check("fill_load_released", 32'(s_load), 32'd0);
        spr_read(2'd1);
        check("fill_buf", s_spr, 32'hA53C0FF0);
        get(5'd4);
        check("get4", s_bits, 32'hA);
        check("get4_stall", 32'(s_stall), 32'd0);
        get(5'd12);
        check("get12", s_bits, 32'h53C);
        get(5'd8);
        check("get8", s_bits, 32'h0F);
        check("get8_stall", 32'(s_stall), 32'd0);

        // stuffing removal
        spr_init(32'h140);
        wait_full();
        spr_read(2'd1);
        check("unstuff_buf", s_spr, 32'hFF123344);
        spr_read(2'd2);
        check("unstuff_addr", s_spr, 32'h145);
        spr_init(32'h180);
        wait_full();
        spr_read(2'd1);
        check("ffff00_buf", s_spr, 32'hFFFF1122);
        spr_read(2'd2);
        check("ffff00_addr", s_spr, 32'h185);

        // stall on a slow memory
        lat = 3;
        spr_init(32'h1C0);
        op = 1; nb = 5'd16; found = 0; k = 0;
        do begin
            step();
            if (s_stall) found = 1;
            k++;
        end while (s_stall && k < 60);
        op = 0;
        check("slow_stall_seen", 32'(found), 32'd1);
        check("slow_stall_released", 32'(s_stall), 32'd0);
        check("slow_get16", s_bits, 32'hBEEF);

        // consume and ack in the same cycle at cnt=8
        lat = 0;
        spr_init(32'h1E0);
        found = 0;
        for (int i = 0; i < 30 && !found; i++) begin
            if (vif.load_byte_o && mq.size() == 8) begin
                get(5'd8);
                found = 1;
            end else begin
                step();
            end
        end
        check("same_cycle_found", 32'(found), 32'd1);
        check("same_cycle_bits", s_bits, 32'h55);
        spr_read(2'd0);
        check("same_cycle_cnt", s_spr, 32'd8);
        spr_read(2'd1);
        check("same_cycle_top", {24'b0, s_spr[31:24]}, 32'h66);

        // address restart while a load is outstanding
        lat = 3;
        spr_init(32'h220);
        found = 0;
        for (int i = 0; i < 40 && !found; i++) begin
            if (vif.load_byte_o && maddr == 32'h220 && !mflush) begin
                spr_init(32'h200);
                found = 1;
            end else begin
                step();
            end
        end
        check("flush_found", 32'(found), 32'd1);
        wait_full();
        spr_read(2'd1);
        check("flush_buf", s_spr, 32'h01020304);
        spr_read(2'd2);
        check("flush_addr", s_spr, 32'h204);

        // reset during a load
        spr_init(32'h300);
        k = 0;
        while (!vif.load_byte_o && k < 20) begin step(); k++; end
        check("rst_mid_load_seen", 32'(vif.load_byte_o), 32'd1);
        rst = 1;
        step();
        rst = 0;
        spr_read(2'd0);
        check("rst2_load", 32'(s_load), 32'd0);
        check("rst2_addr", s_addr, 32'd0);
        check("rst2_stall", 32'(s_stall), 32'd0);
        check("rst2_bits", s_bits, 32'd0);
        check("rst2_cnt", s_spr, 32'd0);

        // randomized traffic, including address wrap and ignored SPR writes
        rand_lat = 1;
        for (int c = 0; c < 4000; c++) begin
            if (!(op && s_stall)) begin
                op = ($urandom_range(0, 1) == 1);
                nb = 5'($urandom_range(0, 24));
            end
            cs = 0; we = 0;
            r = $urandom_range(0, 99);
            if (r < 30) begin
                cs = 1; sa = 2'($urandom_range(0, 3));
            end else if (r < 33) begin
                cs = 1; we = 1; sa = 2'($urandom_range(0, 1)); sd = $urandom;
            end else if (r < 35) begin
                cs = 1; we = 1; sa = 2'(2 + $urandom_range(0, 1));
                sd = ($urandom_range(0, 3) == 0) ? 32'hFFFFFFFC + 32'($urandom_range(0, 3))
                                                 : $urandom;
            end
            step();
        end
        cs = 0; we = 0; op = 0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
